// File: rtl/sum_to_bcd_display_if.sv
// Handshake and display bus between the adder front end and the BCD display stage.
interface sum_to_bcd_display_if;
  logic       start;
  logic [7:0] S;
  logic       Co;
  logic       busy;
  logic       done;
  logic [3:0] Hundreds;
  logic [3:0] Tens;
  logic [3:0] Ones;
  logic [6:0] Hex2;
  logic [6:0] Hex1;
  logic [6:0] Hex0;

  modport master (
    output start, S, Co,
    input  busy, done, Hundreds, Tens, Ones, Hex2, Hex1, Hex0
  );

  modport slave (
    input  start, S, Co,
    output busy, done, Hundreds, Tens, Ones, Hex2, Hex1, Hex0
  );
endinterface

// File: rtl/sum_to_bcd_display.sv
// Captures the 9-bit adder sum, converts it to BCD with a one-bit-per-clock
// double-dabble engine and drives three 7-segment digits.
module sum_to_bcd_display #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  sum_to_bcd_display_if.slave  bus
);

  localparam int unsigned BIN_W = 9;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned REG_W = BIN_W + BCD_W;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [REG_W-1:0]   sreg;
  logic [REG_W-1:0]   sreg_next;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic               done;
  logic [3:0]         hundreds;
  logic [3:0]         tens;
  logic [3:0]         ones;
  logic               blank2;
  logic               blank1;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [SEG_W-1:0] seg_enc(input logic [3:0] d);
    logic [SEG_W-1:0] p;
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  function automatic logic [SEG_W-1:0] seg_drive(input logic [3:0] d, input logic blank);
    logic [SEG_W-1:0] p;
    p = blank ? '0 : seg_enc(d);
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  always_comb begin
    sreg_next = {add3(sreg[20:17]), add3(sreg[16:13]), add3(sreg[12:9]), sreg[8:0]} << 1;
  end

  // Conversion FSM with registered handshake and digit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hundreds <= '0;
      tens     <= '0;
      ones     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sreg  <= {BCD_W'(0), bus.Co, bus.S};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= sreg_next;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            hundreds <= sreg_next[20:17];
            tens     <= sreg_next[16:13];
            ones     <= sreg_next[12:9];
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Leading-zero blanking; the ones digit is always shown.
  assign blank2 = BLANK_LEADING && (hundreds == 4'd0);
  assign blank1 = blank2 && (tens == 4'd0);

  // Output bus: registered handshake/digits, combinational segment decode.
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.Hundreds = hundreds;
  assign bus.Tens     = tens;
  assign bus.Ones     = ones;
  assign bus.Hex2     = seg_drive(hundreds, blank2);
  assign bus.Hex1     = seg_drive(tens, blank1);
  assign bus.Hex0     = seg_drive(ones, 1'b0);

endmodule
